// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: instruction width, the NOP filler,
// PC stride, the default reset vector and the fetch FSM encodings.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_STEP = 2;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t      NOP_INSTR        = 16'hBF00;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // IDLE lasts one cycle after reset so the first request starts a cycle later.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer; clear wins over push/pop so a flush
// leaves it empty regardless of traffic in the same cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic               pop_i,
    input  logic               clear_i,
    output logic [INSTR_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is only accepted when a pop frees the slot.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited instruction fetches, buffers
// responses and hands them to the decoder; redirects flush and refetch.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [15:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  head_pc_q, head_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   stale_q, stale_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [INSTR_W-1:0] fifo_head;

    logic               req_fire;
    logic               drop_rsp;
    logic [SUM_W-1:0]   credit_used;
    logic [CNT_W-1:0]   out_after_rsp;
    logic [ADDR_W-1:0]  redirect_target;
    logic               unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign unused_redirect_lsb = redirect_pc[0];

    // Buffered plus in-flight fetches never exceed DEPTH, so pushes cannot overflow.
    assign credit_used    = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
    assign imem_req_valid = (state_q != ST_IDLE) && !redirect && (credit_used < SUM_W'(DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign drop_rsp      = redirect || (state_q == ST_FLUSH);
    assign fifo_push     = imem_rsp_valid && !drop_rsp;
    assign fifo_pop      = instr_valid && instr_ready;
    assign out_after_rsp = outstanding_q - CNT_W'(imem_rsp_valid);

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : fifo_head;
    assign instr_pc    = head_pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (imem_rsp_data),
        .pop_i   (fifo_pop),
        .clear_i (redirect),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        head_pc_d     = head_pc_q;
        stale_d       = stale_q;
        outstanding_d = out_after_rsp + CNT_W'(req_fire);
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            stale_d    = out_after_rsp;
            fetch_pc_d = redirect_target;
            head_pc_d  = redirect_target;
            state_d    = (out_after_rsp != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end
            if (fifo_pop) begin
                head_pc_d = head_pc_q + ADDR_W'(PC_STEP);
            end
            if (imem_rsp_valid && (stale_q != '0)) begin
                stale_d = stale_q - 1'b1;
            end
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                ST_FLUSH: state_d = (stale_d == '0) ? ST_RUN : ST_FLUSH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            head_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_push && fifo_full && !fifo_pop && !redirect));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory responder, a scoreboard of
// expected (pc, instr) pairs and a monitor that checks every consumed instruction.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] pend_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    logic        hold = 1'b0;
    logic        deliver = 1'b1;
    logic [15:0] exp_addr = 16'h0000;
    logic [15:0] x_addr;
    logic [15:0] a_addr;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (16),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Memory: a request accepted at one edge is answered in the following cycle
    // unless hold is set; answers leave strictly in request order.
    initial begin
        logic        acc;
        logic [15:0] a;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        forever begin
            @(negedge clk);
            acc = reset && imem_req_valid && imem_req_ready;
            a   = imem_addr;
            @(posedge clk);
            #2;
            if (!reset) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (acc) pend_q.push_back(a);
                if (!hold && pend_q.size() > 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(pend_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every consume must match the oldest expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_instr: got pc %h data %h expected none", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", {16'h0, instr_pc}, {16'h0, e.pc});
                    chk("instr_data", {16'h0, instr}, {16'h0, e.data});
                    $display("consume pc=%h instr=%h", instr_pc, instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish within time budget");
        $fatal(1, "timeout");
    end

    task automatic neg();
        @(negedge clk);
        if (reset && imem_req_valid && imem_req_ready) begin
            chk("req_addr", {16'h0, imem_addr}, {16'h0, exp_addr});
            if (deliver) exp_q.push_back({exp_addr, mem_data(exp_addr)});
            exp_addr = exp_addr + 16'd2;
            n_acc++;
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            neg();
            pos();
        end
    endtask

    task automatic drain(input string name);
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        step(6);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 16'h0000;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        reset = 1'b1;
        neg();
        chk("first_cycle_idle", imem_req_valid, 0);
        pos();

        // Streaming with memory and decoder always ready.
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        deliver        = 1'b1;
        neg();
        chk("first_req_valid", imem_req_valid, 1);
        pos();
        step(12);
        drain("drain_stream");

        // Decoder stall: only DEPTH fetches may be taken.
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        n_acc          = 0;
        step(5);
        neg();
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_accepts", n_acc, 2);
        chk("stall_instr_valid", instr_valid, 1);
        pos();
        instr_ready = 1'b1;
        step(4);
        drain("drain_stall");

        // Redirect with two fetches in flight.
        redirect       = 1'b1;
        redirect_pc    = 16'h0010;
        imem_req_ready = 1'b1;
        exp_addr       = 16'h0010;
        neg();
        chk("redir_no_req", imem_req_valid, 0);
        pos();
        redirect = 1'b0;
        hold     = 1'b1;
        deliver  = 1'b0;
        step(3);
        neg();
        chk("inflight_cap", imem_req_valid, 0);
        pos();
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        exp_addr    = 16'h0040;
        neg();
        chk("redir2_no_req", imem_req_valid, 0);
        pos();
        redirect = 1'b0;
        hold     = 1'b0;
        deliver  = 1'b1;
        neg();
        chk("redir_addr", imem_addr, 16'h0040);
        chk("flush_no_valid", instr_valid, 0);
        pos();
        step(6);
        drain("drain_redirect");

        // Redirect coinciding with a response and a consume.
        hold           = 1'b1;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        deliver        = 1'b1;
        a_addr         = exp_addr;
        step(1);
        deliver = 1'b0;
        step(1);
        imem_req_ready = 1'b0;
        hold           = 1'b0;
        step(1);
        redirect    = 1'b1;
        redirect_pc = 16'h0081;
        instr_ready = 1'b1;
        exp_addr    = 16'h0080;
        neg();
        chk("same_cycle_valid", instr_valid, 1);
        chk("same_cycle_pc", instr_pc, a_addr);
        chk("same_cycle_no_req", imem_req_valid, 0);
        pos();
        redirect = 1'b0;
        deliver  = 1'b1;
        neg();
        chk("flushed_empty", instr_valid, 0);
        chk("restart_valid", imem_req_valid, 1);
        chk("restart_addr", imem_addr, 16'h0080);
        pos();
        imem_req_ready = 1'b1;
        step(5);
        drain("drain_same_cycle");

        // Request held stable while memory is not ready.
        x_addr         = exp_addr;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        deliver        = 1'b1;
        step(1);
        imem_req_ready = 1'b0;
        repeat (2) begin
            neg();
            chk("hold_valid", imem_req_valid, 1);
            chk("hold_addr", imem_addr, x_addr + 16'd2);
            pos();
        end
        imem_req_ready = 1'b1;
        step(1);
        imem_req_ready = 1'b0;
        neg();
        chk("advance_addr", imem_addr, x_addr + 16'd4);
        pos();
        drain("drain_hold");

        // Wrap at 0xFFFE, then reset with the buffer full.
        redirect       = 1'b1;
        redirect_pc    = 16'hFFFC;
        exp_addr       = 16'hFFFC;
        imem_req_ready = 1'b0;
        step(1);
        redirect       = 1'b0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        deliver        = 1'b0;
        step(4);
        neg();
        chk("full_no_req", imem_req_valid, 0);
        chk("wrap_addr", imem_addr, 16'h0000);
        chk("full_valid", instr_valid, 1);
        chk("full_pc", instr_pc, 16'hFFFC);
        chk("full_data", instr, mem_data(16'hFFFC));
        pos();
        reset = 1'b0;
        #1;
        chk("mid_rst_instr_valid", instr_valid, 0);
        chk("mid_rst_instr", instr, NOP_INSTR);
        chk("mid_rst_instr_pc", instr_pc, 16'h0000);
        chk("mid_rst_req_valid", imem_req_valid, 0);
        pos();
        pos();
        reset          = 1'b1;
        exp_addr       = 16'h0000;
        deliver        = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        neg();
        chk("post_rst_idle", imem_req_valid, 0);
        pos();
        step(8);
        drain("drain_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
